// File: rtl/prbs10_checker.sv
// Receive-side checker for the x^10 + x^7 + 1 LFSR stream: self-synchronises,
// declares and drops lock, and keeps saturating word/bit error counters.
module prbs10_checker #(
    parameter int LOCK_MATCHES = 4,
    parameter int LOSS_MISSES  = 4,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [9:0]       in_data,
    input  logic             clear_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] word_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic [CNT_W-1:0] word_cnt
);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_MATCHES_W = 4'(LOCK_MATCHES);
    localparam logic [3:0] LOSS_MISSES_W  = 4'(LOSS_MISSES);

    function automatic logic [9:0] next_word(input logic [9:0] x);
        return {x[8:0], x[9] ^ x[6]};
    endfunction

    state_t           r_state;
    state_t           w_state_next;
    logic [9:0]       r_expected;
    logic [9:0]       w_expected_next;
    logic [3:0]       r_match_run;
    logic [3:0]       w_match_run_next;
    logic [3:0]       r_miss_run;
    logic [3:0]       w_miss_run_next;
    logic             r_err_pulse;
    logic [CNT_W-1:0] r_word_err_cnt;
    logic [CNT_W-1:0] r_bit_err_cnt;
    logic [CNT_W-1:0] r_word_cnt;

    logic [9:0]       w_diff;
    logic             w_mismatch;
    logic [3:0]       w_popcnt;
    logic             w_count_en;
    logic             w_err_event;
    logic [CNT_W:0]   w_bit_sum;

    assign w_diff      = in_data ^ r_expected;
    assign w_mismatch  = (w_diff != 10'd0);
    assign w_count_en  = in_valid && (r_state == ST_LOCKED);
    assign w_err_event = w_count_en && w_mismatch;
    // One extra bit so an overflowing add can be detected and clamped.
    assign w_bit_sum   = {1'b0, r_bit_err_cnt} + {{(CNT_W-3){1'b0}}, w_popcnt};

    always_comb begin
        w_popcnt = 4'd0;
        for (int k = 0; k < 10; k++) begin
            w_popcnt = w_popcnt + {3'd0, w_diff[k]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_SEARCH;
            r_expected  <= 10'd0;
            r_match_run <= 4'd0;
            r_miss_run  <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_expected  <= w_expected_next;
            r_match_run <= w_match_run_next;
            r_miss_run  <= w_miss_run_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_expected_next  = r_expected;
        w_match_run_next = r_match_run;
        w_miss_run_next  = r_miss_run;
        if (in_valid) begin
            unique case (r_state)
                ST_SEARCH: begin
                    // An all-zero word is the LFSR lock-up state and cannot seed.
                    if (in_data != 10'd0) begin
                        w_expected_next  = next_word(in_data);
                        w_match_run_next = 4'd0;
                        w_state_next     = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (!w_mismatch) begin
                        w_expected_next  = next_word(in_data);
                        w_match_run_next = r_match_run + 4'd1;
                        if (r_match_run + 4'd1 == LOCK_MATCHES_W) begin
                            w_state_next    = ST_LOCKED;
                            w_miss_run_next = 4'd0;
                        end
                    end else if (in_data != 10'd0) begin
                        w_expected_next  = next_word(in_data);
                        w_match_run_next = 4'd0;
                    end else begin
                        w_state_next = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: never reseed from data, so one bad word is one error.
                    w_expected_next = next_word(r_expected);
                    if (!w_mismatch) begin
                        w_miss_run_next = 4'd0;
                    end else begin
                        w_miss_run_next = r_miss_run + 4'd1;
                        if (r_miss_run + 4'd1 == LOSS_MISSES_W) begin
                            w_state_next     = ST_SEARCH;
                            w_match_run_next = 4'd0;
                        end
                    end
                end
                default: w_state_next = ST_SEARCH;
            endcase
        end
    end

    always_comb begin
        locked       = (r_state == ST_LOCKED);
        err_pulse    = r_err_pulse;
        word_err_cnt = r_word_err_cnt;
        bit_err_cnt  = r_bit_err_cnt;
        word_cnt     = r_word_cnt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_pulse    <= 1'b0;
            r_word_err_cnt <= '0;
            r_bit_err_cnt  <= '0;
            r_word_cnt     <= '0;
        end else begin
            r_err_pulse <= w_err_event;
            if (clear_cnt) begin
                r_word_err_cnt <= '0;
                r_bit_err_cnt  <= '0;
                r_word_cnt     <= '0;
            end else begin
                if (w_count_en && !(&r_word_cnt)) begin
                    r_word_cnt <= r_word_cnt + CNT_W'(1);
                end
                if (w_err_event && !(&r_word_err_cnt)) begin
                    r_word_err_cnt <= r_word_err_cnt + CNT_W'(1);
                end
                if (w_err_event) begin
                    r_bit_err_cnt <= w_bit_sum[CNT_W] ? '1 : w_bit_sum[CNT_W-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_prbs10_checker.sv
// Drives two checker instances (default and long-loss/narrow-counter) with one
// stream and compares every output against a behavioural reference model.
module tb_prbs10_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [9:0] in_data;
    logic       clear_cnt;

    logic        a_locked, a_err_pulse;
    logic [15:0] a_word_err_cnt, a_bit_err_cnt, a_word_cnt;
    logic        b_locked, b_err_pulse;
    logic [5:0]  b_word_err_cnt, b_bit_err_cnt, b_word_cnt;

    prbs10_checker #(.LOCK_MATCHES(4), .LOSS_MISSES(4), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear_cnt(clear_cnt), .locked(a_locked), .err_pulse(a_err_pulse),
        .word_err_cnt(a_word_err_cnt), .bit_err_cnt(a_bit_err_cnt),
        .word_cnt(a_word_cnt)
    );

    prbs10_checker #(.LOCK_MATCHES(4), .LOSS_MISSES(15), .CNT_W(6)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .clear_cnt(clear_cnt), .locked(b_locked), .err_pulse(b_err_pulse),
        .word_err_cnt(b_word_err_cnt), .bit_err_cnt(b_bit_err_cnt),
        .word_cnt(b_word_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0=search 1=verify 2=locked.
    int m_lm  [2] = '{4, 4};
    int m_ls  [2] = '{4, 15};
    int m_max [2] = '{65535, 63};
    int m_mode[2], m_exp[2], m_mr[2], m_ms[2];
    int m_pulse[2], m_wec[2], m_bec[2], m_wc[2];

    int g;

    function automatic int nx(input int x);
        return ((x << 1) & 'h3FF) | (((x >> 9) ^ (x >> 6)) & 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_exp[i] = 0; m_mr[i] = 0; m_ms[i] = 0;
            m_pulse[i] = 0; m_wec[i] = 0; m_bec[i] = 0; m_wc[i] = 0;
        end
    endtask

    task automatic model_step(input int i, input bit v, input int d, input bit c);
        int e;
        m_pulse[i] = 0;
        if (v) begin
            if (m_mode[i] == 0) begin
                if (d != 0) begin
                    m_exp[i] = nx(d); m_mr[i] = 0; m_mode[i] = 1;
                end
            end else if (m_mode[i] == 1) begin
                if (d == m_exp[i]) begin
                    m_exp[i] = nx(d);
                    m_mr[i]++;
                    if (m_mr[i] == m_lm[i]) begin
                        m_mode[i] = 2; m_ms[i] = 0;
                    end
                end else if (d != 0) begin
                    m_exp[i] = nx(d); m_mr[i] = 0;
                end else begin
                    m_mode[i] = 0;
                end
            end else begin
                e = m_exp[i];
                m_exp[i] = nx(e);
                m_wc[i] = (m_wc[i] + 1 > m_max[i]) ? m_max[i] : m_wc[i] + 1;
                if (d == e) begin
                    m_ms[i] = 0;
                end else begin
                    m_pulse[i] = 1;
                    m_wec[i] = (m_wec[i] + 1 > m_max[i]) ? m_max[i] : m_wec[i] + 1;
                    m_bec[i] = m_bec[i] + $countones(10'(d ^ e));
                    if (m_bec[i] > m_max[i]) m_bec[i] = m_max[i];
                    m_ms[i]++;
                    if (m_ms[i] == m_ls[i]) begin
                        m_mode[i] = 0; m_mr[i] = 0;
                    end
                end
            end
        end
        if (c) begin
            m_wec[i] = 0; m_bec[i] = 0; m_wc[i] = 0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("a_locked",  32'(a_locked),  32'(m_mode[0] == 2));
        check("a_err",     32'(a_err_pulse), 32'(m_pulse[0]));
        check("a_wec",     32'(a_word_err_cnt), 32'(m_wec[0]));
        check("a_bec",     32'(a_bit_err_cnt),  32'(m_bec[0]));
        check("a_wc",      32'(a_word_cnt),     32'(m_wc[0]));
        check("b_locked",  32'(b_locked),  32'(m_mode[1] == 2));
        check("b_err",     32'(b_err_pulse), 32'(m_pulse[1]));
        check("b_wec",     32'(b_word_err_cnt), 32'(m_wec[1]));
        check("b_bec",     32'(b_bit_err_cnt),  32'(m_bec[1]));
        check("b_wc",      32'(b_word_cnt),     32'(m_wc[1]));
    endtask

    task automatic cyc(input bit v, input logic [9:0] d, input bit c);
        in_valid  = v;
        in_data   = d;
        clear_cnt = c;
        @(posedge clk);
        for (int i = 0; i < 2; i++) model_step(i, v, int'(d), c);
        #1;
        $display("t=%0t v=%0b d=%03h clr=%0b | a lk=%0b ep=%0b we=%0d be=%0d wc=%0d | b lk=%0b ep=%0b we=%0d be=%0d wc=%0d",
                 $time, v, d, c, a_locked, a_err_pulse, a_word_err_cnt, a_bit_err_cnt, a_word_cnt,
                 b_locked, b_err_pulse, b_word_err_cnt, b_bit_err_cnt, b_word_cnt);
        check_all();
    endtask

    task automatic feed_good(input int n);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, 10'(g), 1'b0);
            g = nx(g);
        end
    endtask

    initial begin
        logic [9:0] mask;
        bit         v;
        rst = 1'b1; in_valid = 1'b0; in_data = 10'd0; clear_cnt = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // Acquire lock from 0x001.
        g = 1;
        for (int k = 0; k < 5; k++) begin
            cyc(1'b1, 10'(g), 1'b0);
            g = nx(g);
            if (k == 3) check("lock_before_5th", 32'(a_locked), 32'd0);
        end
        check("lock_after_5th", 32'(a_locked), 32'd1);
        check("wc_at_lock", 32'(a_word_cnt), 32'd0);

        // 0x020..0x009 then one corrupted word in place of the expected value.
        feed_good(6);
        check("wc_six", 32'(a_word_cnt), 32'd6);
        cyc(1'b1, 10'h3FF, 1'b0);
        check("single_err_pulse", 32'(a_err_pulse), 32'd1);
        check("single_err_wec", 32'(a_word_err_cnt), 32'd1);
        g = nx(g);
        feed_good(2);
        check("pulse_clears", 32'(a_err_pulse), 32'd0);
        check("still_locked", 32'(a_locked), 32'd1);

        // Four zero words drop lock on the default instance, then relock.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 10'd0, 1'b0);
            g = nx(g);
        end
        check("lost_lock", 32'(a_locked), 32'd0);
        check("loss_wec", 32'(a_word_err_cnt), 32'd5);
        g = 1;
        feed_good(5);
        check("relock", 32'(a_locked), 32'd1);

        // Invalid gap changes nothing.
        for (int k = 0; k < 5; k++) cyc(1'b0, 10'($urandom), 1'b0);
        feed_good(3);

        // Asynchronous reset mid-stream takes effect before the next edge.
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst_locked", 32'(a_locked), 32'd0);
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Zero words only: no seed, no lock.
        for (int k = 0; k < 20; k++) cyc(1'b1, 10'd0, 1'b0);
        check("zeros_no_lock", 32'(a_locked), 32'd0);

        // Random stream with gaps and injected errors; drives narrow counters to saturation.
        g = $urandom_range(1, 1023);
        for (int k = 0; k < 400; k++) begin
            v = ($urandom % 8) != 0;
            mask = 10'($urandom_range(1, 1023));
            if (v && ($urandom % 4) == 0) cyc(1'b1, 10'(g) ^ mask, 1'b0);
            else cyc(v, v ? 10'(g) : 10'($urandom), 1'b0);
            if (v) g = nx(g);
        end
        check("sat_wec", 32'(b_word_err_cnt), 32'd63);
        check("sat_bec", 32'(b_bit_err_cnt), 32'd63);

        // Clear together with an error word: counters zero, pulse still fires.
        feed_good(20);
        cyc(1'b1, 10'(g) ^ 10'h155, 1'b1);
        g = nx(g);
        check("clr_wec", 32'(a_word_err_cnt), 32'd0);
        check("clr_pulse", 32'(a_err_pulse), 32'd1);
        feed_good(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
